// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg
//   Shared constants for the universal shift register: the mode select
//   width and the 3-bit operation encodings. Encoding 3'b111 is reserved
//   and decodes as HOLD.
package shift_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;

endpackage

// File: rtl/shift_reg_univ.sv
// shift_reg_univ
//   Parametrised universal register with mode-selected load, shift, rotate
//   and arithmetic shift, plus an autonomous LSB-first serialiser burst.
//
// Ports
//   clk      rising-edge clock
//   clr      synchronous active-high reset; highest priority
//   ce       clock enable; low freezes q, burst counter and busy
//   mode     operation select (shift_reg_pkg MODE_*)
//   d        parallel load data (also the burst payload)
//   sin_lsb  serial input into q[0] on SHL
//   sin_msb  serial input into q[WIDTH-1] on SHR and during a burst
//   start    burst request; taken only when idle with ce high
//   q        register contents
//   sout     serial output, always q[0]
//   busy     high while a burst is in progress
//   done     one-cycle pulse on the edge that completes a burst
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ce,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_lsb,
    input  logic              sin_msb,
    input  logic              start,
    output logic [WIDTH-1:0]  q,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_last;

    // The burst's final shift happens on the edge where the counter already
    // holds WIDTH-1, so busy covers exactly WIDTH ce-qualified cycles.
    assign w_last = r_busy && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q    <= RESET_VAL;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (ce) begin
            if (r_busy) begin
                // Mode and start are ignored while serialising.
                r_q <= {sin_msb, r_q[WIDTH-1:1]};
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (start) begin
                r_q    <= d;
                r_busy <= 1'b1;
                r_cnt  <= '0;
            end else begin
                case (mode)
                    MODE_LOAD: r_q <= d;
                    MODE_SHL:  r_q <= {r_q[WIDTH-2:0], sin_lsb};
                    MODE_SHR:  r_q <= {sin_msb, r_q[WIDTH-1:1]};
                    MODE_ROL:  r_q <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    MODE_ROR:  r_q <= {r_q[0], r_q[WIDTH-1:1]};
                    MODE_ASR:  r_q <= {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                    default:   r_q <= r_q;
                endcase
            end
        end
    end

    // done self-clears on every edge regardless of ce; an aborted burst
    // never reaches w_last with clr low, so it produces no pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_done <= 1'b0;
        end else begin
            r_done <= ce && w_last;
        end
    end

    assign q    = r_q;
    assign sout = r_q[0];
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    localparam int W = 4;

    logic              clk;
    logic              clr;
    logic              ce;
    logic [MODE_W-1:0] mode;
    logic [W-1:0]      d;
    logic              sin_lsb;
    logic              sin_msb;
    logic              start;
    logic [W-1:0]      q;
    logic              sout;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    shift_reg_univ #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
        .clk(clk), .clr(clr), .ce(ce), .mode(mode), .d(d),
        .sin_lsb(sin_lsb), .sin_msb(sin_msb), .start(start),
        .q(q), .sout(sout), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; ce = 1'b1; start = 1'b0;
        mode = MODE_LOAD; d = 4'b1011;
        step();
        checks++;
        if (q !== 4'b1011) begin
            failures++; $display("FAIL reset_preload q=%b exp=%b", q, 4'b1011);
        end
        clr = 1'b1; mode = MODE_HOLD;
        step();
        clr = 1'b0;
        checks++;
        if (q !== 4'b0000) begin
            failures++; $display("FAIL reset_q q=%b exp=%b", q, 4'b0000);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_status busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_ce_hold();
        ce = 1'b0; mode = MODE_LOAD; d = 4'b1111;
        step();
        step();
        checks++;
        if (q !== 4'b0000) begin
            failures++; $display("FAIL ce_hold q=%b exp=%b", q, 4'b0000);
        end
        ce = 1'b1; mode = MODE_HOLD;
    endtask

    task automatic test_modes();
        logic [MODE_W-1:0] m_tab [7];
        logic [W-1:0]      e_tab [7];
        logic              sl_tab[7];
        logic              sm_tab[7];
        m_tab = '{MODE_LOAD, MODE_SHL, MODE_ROR, MODE_ASR, MODE_ROL, MODE_SHR, 3'b111};
        e_tab = '{4'b1000, 4'b0001, 4'b1000, 4'b1100, 4'b1001, 4'b0100, 4'b0100};
        sl_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        sm_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ce = 1'b1; d = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            mode = m_tab[i]; sin_lsb = sl_tab[i]; sin_msb = sm_tab[i];
            step();
            checks++;
            if (q !== e_tab[i] || sout !== e_tab[i][0]) begin
                failures++;
                $display("FAIL mode_%0d q=%b sout=%b exp=%b", i, q, sout, e_tab[i]);
            end
        end
        mode = MODE_HOLD;
    endtask

    task automatic test_burst();
        logic [W-1:0] bits;
        int pulses;
        bits = 4'b1011; pulses = 0;
        ce = 1'b1; sin_msb = 1'b0; d = 4'b1011; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (sout !== bits[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL burst_bit%0d sout=%b busy=%b exp=%b/1", i, sout, busy, bits[i]);
            end
            if (done === 1'b1) pulses++;
            step();
        end
        if (done === 1'b1) pulses++;
        checks++;
        if (busy !== 1'b0 || q !== 4'b0000) begin
            failures++; $display("FAIL burst_end busy=%b q=%b exp=0/0000", busy, q);
        end
        step();
        if (done === 1'b1) pulses++;
        checks++;
        if (pulses != 1) begin
            failures++; $display("FAIL burst_done_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_burst_ce_gap();
        ce = 1'b1; sin_msb = 1'b0; d = 4'b1011; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (sout !== 1'b1) begin
            failures++; $display("FAIL gap_bit0 sout=%b exp=1", sout);
        end
        step();
        checks++;
        if (sout !== 1'b1) begin
            failures++; $display("FAIL gap_bit1 sout=%b exp=1", sout);
        end
        ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (sout !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL gap_frozen%0d sout=%b busy=%b done=%b exp=1/1/0", i, sout, busy, done);
            end
        end
        ce = 1'b1;
        step();
        checks++;
        if (sout !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL gap_bit2 sout=%b busy=%b exp=0/1", sout, busy);
        end
        step();
        checks++;
        if (sout !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL gap_bit3 sout=%b busy=%b done=%b exp=1/1/0", sout, busy, done);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            failures++; $display("FAIL gap_done busy=%b done=%b exp=0/1", busy, done);
        end
        // done must self-clear even with ce low
        ce = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL gap_done_clear done=%b busy=%b exp=0/0", done, busy);
        end
        ce = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] bits;
        bits = 4'b1011;
        ce = 1'b1; sin_msb = 1'b0; d = 4'b1011; start = 1'b1;
        step();
        // Disturb mode/start/d during the burst; all must be ignored.
        mode = MODE_LOAD; d = 4'b1111;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (sout !== bits[i] || busy !== 1'b1) begin
                failures++;
                $display("FAIL ign_bit%0d sout=%b busy=%b exp=%b/1", i, sout, busy, bits[i]);
            end
            step();
        end
        // start was high on the completing edge: no new burst.
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_done done=%b busy=%b q=%b exp=1/0/0000", done, busy, q);
        end
        d = 4'b0110;
        step();
        checks++;
        if (busy !== 1'b1 || q !== 4'b0110 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart busy=%b q=%b done=%b exp=1/0110/0", busy, q, done);
        end
        start = 1'b0; mode = MODE_HOLD;
    endtask

    task automatic test_clr_mid_burst();
        int pulses;
        pulses = 0;
        // Burst from the previous task is in progress.
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL clr_abort q=%b busy=%b done=%b exp=0000/0/0", q, busy, done);
        end
        for (int i = 0; i < W + 1; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || q !== 4'b0000) begin
            failures++; $display("FAIL clr_no_done events=%0d q=%b exp=0/0000", pulses, q);
        end
    endtask

    initial begin
        clr = 1'b1; ce = 1'b0; mode = MODE_HOLD; d = '0;
        sin_lsb = 1'b0; sin_msb = 1'b0; start = 1'b0;
        step();
        step();
        test_reset();
        test_ce_hold();
        test_modes();
        test_burst();
        test_burst_ce_gap();
        test_back_to_back();
        test_clr_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
